// File: rtl/pipeline_hazard_ctl.sv
// Hazard/sequencing controller: scoreboard-based RAW stall, memory-wait freeze, jump flush.
// Optional build macro HAZARD_FWD_EN adds forwarding selects and limits stalls to load-use.
module pipeline_hazard_ctl #(
  parameter int NREG_W    = 4,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     id_valid,
  input  logic [NREG_W-1:0]        id_a_addr,
  input  logic [NREG_W-1:0]        id_b_addr,
  input  logic                     id_uses_a,
  input  logic                     id_uses_b,
  input  logic [NREG_W-1:0]        id_c_addr,
  input  logic                     id_reg_write,
  input  logic                     id_data_read,
  input  logic                     ex_jump_taken,
  input  logic                     mem_busy,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     bubble_ex,
  output logic                     flush_if,
  output logic                     flush_id,
  output logic                     freeze,
  output logic [CNT_W-1:0]         stall_cnt,
`ifdef HAZARD_FWD_EN
  output logic [1:0]               fwd_a_sel,
  output logic [1:0]               fwd_b_sel,
`endif
  output logic [1:0]               dbg_state,
  output logic [3*(NREG_W+2)-1:0]  dbg_sb
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [NREG_W-1:0] addr;
    logic              is_load;
  } sb_entry_t;

  // The jump cycle itself is the first flush cycle; FLUSH covers the rest.
  localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t            state_q, state_d;
  logic [1:0]        fcnt_q, fcnt_d;
  sb_entry_t         ex_q, mem_q, wb_q, ex_d;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic a_ex, a_mem, b_ex, b_mem;
  logic raw_hz, flush_now, issue;

  function automatic logic hit(input sb_entry_t e, input logic [NREG_W-1:0] a);
    return e.valid && (e.addr == a);
  endfunction

  assign a_ex  = id_uses_a && hit(ex_q,  id_a_addr);
  assign a_mem = id_uses_a && hit(mem_q, id_a_addr);
  assign b_ex  = id_uses_b && hit(ex_q,  id_b_addr);
  assign b_mem = id_uses_b && hit(mem_q, id_b_addr);

`ifdef HAZARD_FWD_EN
  // Only a load still in EX cannot be forwarded yet.
  assign raw_hz = id_valid && ex_q.is_load && (a_ex || b_ex);
`else
  assign raw_hz = id_valid && (a_ex || a_mem || b_ex || b_mem);
`endif

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_now = 1'b0;
    freeze    = 1'b0;
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    if (RST_N) begin
      freeze = mem_busy;
      if (mem_busy) begin
        // A memory wait inside FLUSH pauses the countdown rather than leaving FLUSH.
        if (state_q != ST_FLUSH) state_d = ST_FREEZE;
      end else if (state_q == ST_FLUSH) begin
        flush_now = 1'b1;
        fcnt_d    = fcnt_q - 2'd1;
        if (fcnt_q <= 2'd1) state_d = ST_RUN;
      end else begin
        state_d = ST_RUN;
        if (ex_jump_taken) begin
          flush_now = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_INIT;
          end
        end else if (raw_hz) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
      if (flush_now) bubble_ex = 1'b1;
    end
  end

  assign flush_if = flush_now;
  assign flush_id = flush_now;

  assign issue = id_valid && id_reg_write && !bubble_ex;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid   = 1'b1;
      ex_d.addr    = id_c_addr;
      ex_d.is_load = id_data_read;
    end
  end

`ifdef HAZARD_FWD_EN
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (RST_N && !mem_busy && !flush_now) begin
      if (a_ex)       fwd_a_sel = 2'b01;
      else if (a_mem) fwd_a_sel = 2'b10;
      if (b_ex)       fwd_b_sel = 2'b01;
      else if (b_mem) fwd_b_sel = 2'b10;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_RUN;
      fcnt_q      <= 2'd0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (!freeze) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= ex_d;
      end
      if ((stall_id || freeze) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;
  assign dbg_sb    = {ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Directed bench for pipeline_hazard_ctl (FLUSH_CYC=2, 4-bit stall counter for a short saturation run).
// Control vector order: {stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze}.
module tb_pipeline_hazard_ctl;

  localparam int NREG_W = 4;
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b111000;
  localparam logic [5:0] C_FLUSH = 6'b001110;
  localparam logic [5:0] C_FRZ   = 6'b000001;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic id_valid, id_uses_a, id_uses_b, id_reg_write, id_data_read;
  logic [NREG_W-1:0] id_a_addr, id_b_addr, id_c_addr;
  logic ex_jump_taken, mem_busy;
  logic stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze;
  logic [3:0]  stall_cnt;
  logic [1:0]  dbg_state;
  logic [17:0] dbg_sb;
`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_sel, fwd_b_sel;
`endif

  logic [5:0] ctl;
  assign ctl = {stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze};

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_cnt = 4'd0;
  logic [5:0] exp_q[$];

  pipeline_hazard_ctl #(.NREG_W(NREG_W), .FLUSH_CYC(2), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .id_valid(id_valid), .id_a_addr(id_a_addr), .id_b_addr(id_b_addr),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .id_c_addr(id_c_addr),
    .id_reg_write(id_reg_write), .id_data_read(id_data_read),
    .ex_jump_taken(ex_jump_taken), .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if(flush_if), .flush_id(flush_id), .freeze(freeze),
    .stall_cnt(stall_cnt),
`ifdef HAZARD_FWD_EN
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`endif
    .dbg_state(dbg_state), .dbg_sb(dbg_sb)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check combinational outputs mid-cycle, advance, update the counter model.
  task automatic cyc(input string tag, input logic [5:0] e, input logic [3:0] ef);
    @(negedge CLK);
    chk($sformatf("%s_ctl(f%0h)", tag, ef), 32'(ctl), 32'(e));
    chk({tag, "_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
`ifdef HAZARD_FWD_EN
    chk({tag, "_fwd"}, 32'({fwd_a_sel, fwd_b_sel}), 32'(ef));
`endif
    @(posedge CLK); #1;
    if ((e[4] || e[0]) && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic drain(input string tag);
    logic [5:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc(tag, e, 4'b0000);
    end
  endtask

  task automatic clr_in();
    id_valid = 0; id_uses_a = 0; id_uses_b = 0; id_reg_write = 0; id_data_read = 0;
    id_a_addr = 0; id_b_addr = 0; id_c_addr = 0; ex_jump_taken = 0; mem_busy = 0;
  endtask

  task automatic drv_write(input logic [3:0] c, input logic ld);
    clr_in();
    id_valid = 1; id_reg_write = 1; id_c_addr = c; id_data_read = ld;
  endtask

  task automatic idle3();
    clr_in();
    repeat (3) cyc("idle", C_IDLE, 4'b0000);
  endtask

  initial begin
    clr_in();
    // reset state
    #1 RST_N = 0;
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_sb", 32'(dbg_sb), 32'd0);
    @(posedge CLK); #1 RST_N = 1;

    // ALU write r3, then reader of r3 as source A (also writes r4)
    drv_write(4'd3, 1'b0);
    cyc("t2_prod", C_IDLE, 4'b0000);
    drv_write(4'd4, 1'b0);
    id_uses_a = 1; id_a_addr = 4'd3;
`ifdef HAZARD_FWD_EN
    cyc("t2_fwd_ex", C_IDLE, 4'b0100);
    clr_in(); id_valid = 1; id_uses_a = 1; id_a_addr = 4'd3;
    cyc("t2_fwd_mem", C_IDLE, 4'b1000);
    chk("t2_cnt_total", 32'(stall_cnt), 32'd0);
`else
    cyc("t2_stall0", C_STALL, 4'b0000);
    cyc("t2_stall1", C_STALL, 4'b0000);
    cyc("t2_issue", C_IDLE, 4'b0000);
    chk("t2_cnt_total", 32'(stall_cnt), 32'd2);
`endif
    idle3();

    // load r5, then use r5 as source B
    drv_write(4'd5, 1'b1);
    cyc("t3_load", C_IDLE, 4'b0000);
    clr_in(); id_valid = 1; id_uses_b = 1; id_b_addr = 4'd5;
`ifdef HAZARD_FWD_EN
    cyc("t3_luse", C_STALL, 4'b0001);
    cyc("t3_fwd", C_IDLE, 4'b0010);
`else
    exp_q.push_back(C_STALL);
    exp_q.push_back(C_STALL);
    exp_q.push_back(C_IDLE);
    drain("t3");
`endif
    idle3();

    // jump taken while decode has a RAW hazard on r6: flush wins for 2 cycles
    drv_write(4'd6, 1'b0);
    cyc("t4_prod", C_IDLE, 4'b0000);
    clr_in(); id_valid = 1; id_uses_a = 1; id_a_addr = 4'd6; ex_jump_taken = 1;
    cyc("t4_jump", C_FLUSH, 4'b0000);
    chk("t4_state_flush", 32'(dbg_state), 32'd2);
    ex_jump_taken = 0;
    cyc("t4_flush2", C_FLUSH, 4'b0000);
    chk("t4_state_run", 32'(dbg_state), 32'd0);
    cyc("t4_after", C_IDLE, 4'b0000);
    idle3();

    // mem_busy for 3 cycles during a pending stall on load r7
    drv_write(4'd7, 1'b1);
    cyc("t5_load", C_IDLE, 4'b0000);
    clr_in(); id_valid = 1; id_uses_a = 1; id_a_addr = 4'd7; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_sb_hold", 32'(dbg_sb), 32'h2F000);
      cyc("t5_frz", C_FRZ, 4'b0000);
      chk("t5_state_frz", 32'(dbg_state), 32'd1);
    end
    chk("t5_sb_after", 32'(dbg_sb), 32'h2F000);
    mem_busy = 0;
`ifdef HAZARD_FWD_EN
    cyc("t5_resume", C_STALL, 4'b0100);
    cyc("t5_fwd", C_IDLE, 4'b1000);
`else
    cyc("t5_resume", C_STALL, 4'b0000);
    cyc("t5_stall_mem", C_STALL, 4'b0000);
    cyc("t5_issue", C_IDLE, 4'b0000);
`endif
    idle3();

    // long memory wait saturates the counter
    mem_busy = 1;
    repeat (20) cyc("t6_busy", C_FRZ, 4'b0000);
    chk("t6_sat", 32'(stall_cnt), 32'hF);
    mem_busy = 0;
    cyc("t6_idle", C_IDLE, 4'b0000);

    // reset in the middle of FLUSH
    clr_in(); ex_jump_taken = 1;
    cyc("t7_jump", C_FLUSH, 4'b0000);
    ex_jump_taken = 0;
    #1;
    chk("t7_in_flush", 32'(dbg_state), 32'd2);
    chk("t7_flush_out", 32'(ctl), 32'(C_FLUSH));
    RST_N = 0;
    #1;
    chk("t7_rst_ctl", 32'(ctl), 32'(C_IDLE));
    chk("t7_rst_state", 32'(dbg_state), 32'd0);
    chk("t7_rst_cnt", 32'(stall_cnt), 32'd0);
    exp_cnt = 4'd0;
    #2 RST_N = 1;
    @(posedge CLK); #1;
    cyc("t7_post", C_IDLE, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctl.md
Name: pipeline_hazard_ctl

Overview:
Hazard and sequencing controller for the 16-bit pipelined core. It issues stall, flush and bubble controls to the fetch/decode register and the decode-to-execute register.
- Tracks in-flight register writes in a 3-entry scoreboard (EX, MEM, WB).
- Detects read-after-write hazards and freezes the pipe while data memory is busy.
- Flushes wrong-path instructions on a taken jump.

Parameters:
NREG_W, 4, register address width (16-entry register file)
FLUSH_CYC, 1, cycles flush_if/flush_id stay asserted after a taken jump (1..3)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a valid instruction
id_a_addr  in  NREG_W  decode source A register
id_b_addr  in  NREG_W  decode source B register
id_uses_a  in  1  instruction reads source A
id_uses_b  in  1  instruction reads source B
id_c_addr  in  NREG_W  decode destination register
id_reg_write  in  1  instruction writes id_c_addr
id_data_read  in  1  instruction is a load (result available after MEM)
ex_jump_taken  in  1  jump in EX resolved taken (JCTL evaluated)
mem_busy  in  1  data memory not ready; whole pipe must hold
stall_if  out  1  hold PC and fetch/decode register
stall_id  out  1  hold decode stage
bubble_ex  out  1  load a NOP (reg_write=0, data_write=0, data_read=0) into decode-to-execute register
flush_if  out  1  invalidate fetch/decode register
flush_id  out  1  invalidate decode stage
freeze  out  1  hold every pipeline register (memory wait)
stall_cnt  out  CNT_W  saturating count of cycles with stall_id or freeze high

Behaviour:
- Reset (RST_N low, asynchronous): scoreboard entries invalid, state RUN, flush counter 0, stall_cnt 0, all control outputs 0.
- Scoreboard entry = {valid, addr, is_load}.
- Scoreboard advance, when freeze=0: WB<=MEM, MEM<=EX.
  - EX<={id_valid&id_reg_write, id_c_addr, id_data_read} when the instruction issues.
  - EX is set invalid when bubble_ex=1 or a flush is active.
- Scoreboard hold: when freeze=1, all entries hold.
- Register file writes in first half-cycle, decode reads in second, so a WB match is never a hazard.
- RAW hazard (no forwarding): id_valid and (id_uses_a & match(a) | id_uses_b & match(b)). match(x) = valid entry in EX or MEM with addr==x.
- On hazard: stall_if=1, stall_id=1, bubble_ex=1, combinational, same cycle. Lasts until the producing entry leaves MEM: 2 cycles for an EX match, 1 cycle for a MEM match.
- States:
  - RUN: normal; hazard logic active.
  - FREEZE: entered when mem_busy=1; freeze=1, all other outputs 0, scoreboard held. ex_jump_taken is ignored here; upstream holds it. Returns to RUN the cycle mem_busy=0 and re-evaluates hazards.
  - FLUSH: entered from RUN on ex_jump_taken=1. flush_if=flush_id=1 and bubble_ex=1 for FLUSH_CYC cycles via down-counter, then RUN. stall outputs are 0 during FLUSH.
- Priority, same cycle: mem_busy > ex_jump_taken > RAW hazard.
  - Jump and hazard together: flush wins, no stall.
  - mem_busy during FLUSH: counter pauses, freeze=1; resumes when busy drops.
- Outputs are combinational from state plus inputs; state, counter and scoreboard are registered.
- stall_cnt increments on any cycle with stall_id|freeze and saturates at all-ones, with no wrap.

Optional Feature:
Macro HAZARD_FWD_EN.
- Defined:
  - Adds outputs fwd_a_sel[1:0] and fwd_b_sel[1:0]: 00 = register file, 01 = EX result, 10 = MEM result. The youngest match (EX over MEM) wins.
  - Stall only on load-use: EX entry is_load and matches a used source. This gives exactly 1 stall cycle, after which the data forwards from MEM.
  - No stall for ALU-to-ALU dependencies.
  - fwd_*_sel = 00 when the source is unused, during FREEZE/FLUSH, and in reset.
- Undefined: no fwd ports; full RAW stall as above.

Test Plan:
- Reset mid-FLUSH: jump taken, RST_N low next cycle -> all outputs 0 immediately, state RUN, stall_cnt 0.
- ALU write r3 issued, next instr reads r3 as A (no fwd) -> stall_if/stall_id/bubble_ex high 2 cycles, then issue; stall_cnt=2.
- Same sequence with HAZARD_FWD_EN -> no stall, fwd_a_sel=01; one cycle later a reader of r3 sees fwd_a_sel=10.
- Load r5 then use r5 as B with HAZARD_FWD_EN -> 1 stall cycle, then fwd_b_sel=10.
- ex_jump_taken with FLUSH_CYC=2 while decode also has a RAW hazard -> flush_if/flush_id/bubble_ex high 2 cycles, stall_id 0.
- mem_busy high 3 cycles during a pending RAW stall -> freeze=1 for 3 cycles, scoreboard unchanged, stall resumes after; stall_cnt saturates at 16'hFFFF under a long held mem_busy.
